// File: rtl/wdata_chan_mngr.sv
// Write-data / write-response channel manager.
// Tracks addresses accepted upstream, requests the data bus, drives one write beat per
// accepted address from the id/data FIFO head, pops that FIFO on each accepted beat, and
// retires writes as matching responses come back.
module wdata_chan_mngr #(
    parameter logic [1:0] WDC_M_ID = 2'b00,
    parameter logic [2:0] OUTS_MAX = 3'd4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         next_rq,
    input  logic [3:0]   next_id,
    input  logic [15:0]  next_mask,
    input  logic [127:0] next_data,
    output logic         ren_id_data,
    output logic         req_wd,
    input  logic         gnt_wd,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [3:0]   w_id,
    output logic [15:0]  w_mask,
    output logic [127:0] w_data,
    input  logic         b_valid,
    input  logic [3:0]   b_id,
    output logic         b_ready,
    output logic         wr_done,
    output logic [3:0]   wr_done_id,
    output logic         err
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StOut  = 2'b10,
        StDefo = 2'b11
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] pend_cnt_q, pend_cnt_d;
    logic [2:0] outs_cnt_q, outs_cnt_d;
    logic       err_q, err_d;
    logic       wr_done_q;
    logic [3:0] wr_done_id_q;

    logic own_id;
    logic b_acc;
    logic pend_ovf;
    logic b_orphan;

    // FIFO head is presented directly; the FIFO only advances on an accepted beat.
    assign w_id        = next_id;
    assign w_mask      = next_mask;
    assign w_data      = next_data;
    assign ren_id_data = w_valid & w_ready;

    assign own_id   = (b_id[3:2] == WDC_M_ID);
    assign b_acc    = b_valid & own_id & (outs_cnt_q != 3'd0);
    assign b_ready  = b_acc;
    // Own-id response with nothing outstanding is a protocol violation.
    assign b_orphan = b_valid & own_id & (outs_cnt_q == 3'd0);

    assign wr_done    = wr_done_q;
    assign wr_done_id = wr_done_id_q;
    assign err        = err_q;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pend_cnt_q   <= 3'd0;
            outs_cnt_q   <= 3'd0;
            err_q        <= 1'b0;
            wr_done_q    <= 1'b0;
            wr_done_id_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            pend_cnt_q   <= pend_cnt_d;
            outs_cnt_q   <= outs_cnt_d;
            err_q        <= err_d;
            wr_done_q    <= b_acc;
            wr_done_id_q <= b_acc ? b_id : 4'd0;
        end
    end

    // Next-state logic for the data-beat FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if ((pend_cnt_q != 3'd0) && (outs_cnt_q < OUTS_MAX)) state_d = StReq;
            StReq:  if (gnt_wd) state_d = StOut;
            StOut:  if (w_ready) state_d = StIdle;
            StDefo: state_d = StDefo;
        endcase
    end

    // FSM outputs: bus request in REQ, data valid in OUT, nothing elsewhere.
    always_comb begin
        req_wd  = 1'b0;
        w_valid = 1'b0;
        unique case (state_q)
            StIdle: ;
            StReq:  req_wd = 1'b1;
            StOut:  w_valid = 1'b1;
            StDefo: ;
        endcase
    end

    // Pending/outstanding counters and sticky error.
    always_comb begin
        pend_cnt_d = pend_cnt_q;
        outs_cnt_d = outs_cnt_q;
        pend_ovf   = 1'b0;
        if (next_rq && !ren_id_data) begin
            if (pend_cnt_q == 3'd4) begin
                pend_ovf = 1'b1;
            end else begin
                pend_cnt_d = pend_cnt_q + 3'd1;
            end
        end else if (!next_rq && ren_id_data) begin
            pend_cnt_d = pend_cnt_q - 3'd1;
        end
        if (ren_id_data && !b_acc) begin
            outs_cnt_d = outs_cnt_q + 3'd1;
        end else if (!ren_id_data && b_acc) begin
            outs_cnt_d = outs_cnt_q - 3'd1;
        end
        err_d = err_q | pend_ovf | b_orphan;
    end

endmodule

// File: tb/tb_wdata_chan_mngr.sv
// Directed self-checking bench for wdata_chan_mngr.
module tb_wdata_chan_mngr;

    logic         clk;
    logic         rst_n;
    logic         next_rq;
    logic [3:0]   next_id;
    logic [15:0]  next_mask;
    logic [127:0] next_data;
    logic         ren_id_data;
    logic         req_wd;
    logic         gnt_wd;
    logic         w_valid;
    logic         w_ready;
    logic [3:0]   w_id;
    logic [15:0]  w_mask;
    logic [127:0] w_data;
    logic         b_valid;
    logic [3:0]   b_id;
    logic         b_ready;
    logic         wr_done;
    logic [3:0]   wr_done_id;
    logic         err;

    int vectors;
    int miscompares;

    wdata_chan_mngr dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_rq     (next_rq),
        .next_id     (next_id),
        .next_mask   (next_mask),
        .next_data   (next_data),
        .ren_id_data (ren_id_data),
        .req_wd      (req_wd),
        .gnt_wd      (gnt_wd),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_id        (w_id),
        .w_mask      (w_mask),
        .w_data      (w_data),
        .b_valid     (b_valid),
        .b_id        (b_id),
        .b_ready     (b_ready),
        .wr_done     (wr_done),
        .wr_done_id  (wr_done_id),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; next_rq = 0; gnt_wd = 0; w_ready = 0; b_valid = 0; b_id = 4'h0;
        next_id = 4'h5; next_mask = 16'h00ff; next_data = 128'h0123_4567_89ab_cdef;
        step(); step();
        #1;
        vectors++;
        if ({req_wd, w_valid, ren_id_data, b_ready, wr_done, err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outs: got %b want 000000",
                     {req_wd, w_valid, ren_id_data, b_ready, wr_done, err});
        end
        vectors++;
        if (dut.pend_cnt_q !== 3'd0 || dut.outs_cnt_q !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_cnts: got pend %0d outs %0d want 0 0",
                     dut.pend_cnt_q, dut.outs_cnt_q);
        end
        vectors++;
        if (w_data !== 128'h0123_4567_89ab_cdef || w_id !== 4'h5) begin
            miscompares++;
            $display("FAIL reset_pass: got id %h data %h want 5 0123456789abcdef", w_id, w_data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        next_id = 4'h1; next_mask = 16'hffff; next_data = 128'hcafe_f00d;
        next_rq = 1; step();                       // cycle 1
        next_rq = 0; #1;
        vectors++;
        if (dut.pend_cnt_q !== 3'd1 || req_wd !== 1'b0) begin
            miscompares++;
            $display("FAIL single_c1: got pend %0d req %b want 1 0", dut.pend_cnt_q, req_wd);
        end
        step();                                    // cycle 2
        vectors++;
        if (req_wd !== 1'b1) begin
            miscompares++; $display("FAIL single_req: got %b want 1", req_wd);
        end
        gnt_wd = 1; step();                        // cycle 3
        gnt_wd = 0; w_ready = 1; #1;
        vectors++;
        if ({w_valid, ren_id_data} !== 2'b11 || w_id !== 4'h1 || w_mask !== 16'hffff) begin
            miscompares++;
            $display("FAIL single_beat: got v/ren %b id %h mask %h want 11 1 ffff",
                     {w_valid, ren_id_data}, w_id, w_mask);
        end
        step();                                    // cycle 4
        w_ready = 0; #1;
        vectors++;
        if (w_valid !== 1'b0 || dut.outs_cnt_q !== 3'd1 || dut.pend_cnt_q !== 3'd0) begin
            miscompares++;
            $display("FAIL single_c4: got v %b outs %0d pend %0d want 0 1 0",
                     w_valid, dut.outs_cnt_q, dut.pend_cnt_q);
        end
        step(); step();                            // cycle 6
        b_valid = 1; b_id = 4'h1; #1;
        vectors++;
        if (b_ready !== 1'b1) begin
            miscompares++; $display("FAIL single_bready: got %b want 1", b_ready);
        end
        step();                                    // cycle 7
        b_valid = 0; #1;
        vectors++;
        if (wr_done !== 1'b1 || wr_done_id !== 4'h1 || dut.outs_cnt_q !== 3'd0) begin
            miscompares++;
            $display("FAIL single_done: got done %b id %h outs %0d want 1 1 0",
                     wr_done, wr_done_id, dut.outs_cnt_q);
        end
        step();
        vectors++;
        if (wr_done !== 1'b0) begin
            miscompares++; $display("FAIL single_done_pulse: got %b want 0", wr_done);
        end
    endtask

    task automatic test_backpressure();
        int req_n = 0;
        int wv_n = 0;
        int ren_n = 0;
        int bad_data = 0;
        next_id = 4'h1; next_data = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
        next_rq = 1; step();
        next_rq = 0;
        for (int c = 1; c < 15; c++) begin
            gnt_wd = (c == 7); w_ready = (c == 11); #1;
            if (req_wd) req_n++;
            if (w_valid) begin
                wv_n++;
                if (w_data !== 128'hdead_beef_0000_1111_2222_3333_4444_5555) bad_data++;
            end
            if (ren_id_data) ren_n++;
            step();
        end
        gnt_wd = 0; w_ready = 0;
        vectors++;
        if (req_n != 6) begin miscompares++; $display("FAIL bp_req: got %0d want 6", req_n); end
        vectors++;
        if (wv_n != 4) begin miscompares++; $display("FAIL bp_wvalid: got %0d want 4", wv_n); end
        vectors++;
        if (ren_n != 1 || bad_data != 0) begin
            miscompares++;
            $display("FAIL bp_ren_data: got ren %0d bad %0d want 1 0", ren_n, bad_data);
        end
        b_valid = 1; b_id = 4'h1; step();
        b_valid = 0; #1;
        vectors++;
        if (dut.outs_cnt_q !== 3'd0) begin
            miscompares++; $display("FAIL bp_drain: got %0d want 0", dut.outs_cnt_q);
        end
    endtask

    task automatic test_four_writes();
        int ren_n = 0;
        int stall_bad = 0;
        next_id = 4'h2; gnt_wd = 1; w_ready = 1;
        for (int c = 0; c < 25; c++) begin
            next_rq = (c < 4); #1;
            if (ren_id_data) ren_n++;
            step();
        end
        next_rq = 0; #1;
        vectors++;
        if (ren_n != 4 || dut.outs_cnt_q !== 3'd4 || dut.pend_cnt_q !== 3'd0) begin
            miscompares++;
            $display("FAIL four_issue: got ren %0d outs %0d pend %0d want 4 4 0",
                     ren_n, dut.outs_cnt_q, dut.pend_cnt_q);
        end
        next_rq = 1; step();
        next_rq = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (req_wd || w_valid) stall_bad++;
            step();
        end
        vectors++;
        if (stall_bad != 0 || dut.pend_cnt_q !== 3'd1 || dut.state_q !== 2'b00) begin
            miscompares++;
            $display("FAIL four_hold: got stall %0d pend %0d st %0d want 0 1 0",
                     stall_bad, dut.pend_cnt_q, dut.state_q);
        end
        b_valid = 1; b_id = 4'h2; #1;
        vectors++;
        if (b_ready !== 1'b1) begin
            miscompares++; $display("FAIL four_bready: got %b want 1", b_ready);
        end
        step();
        b_valid = 0; ren_n = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (ren_id_data) ren_n++;
            step();
        end
        vectors++;
        if (ren_n != 1 || dut.outs_cnt_q !== 3'd4) begin
            miscompares++;
            $display("FAIL four_fifth: got ren %0d outs %0d want 1 4", ren_n, dut.outs_cnt_q);
        end
        gnt_wd = 0; w_ready = 0;
        b_valid = 1; step(); step(); step();
        b_valid = 0; #1;
        vectors++;
        if (dut.outs_cnt_q !== 3'd1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL four_drain: got outs %0d err %b want 1 0", dut.outs_cnt_q, err);
        end
    endtask

    task automatic test_simultaneous();
        next_id = 4'h3;
        next_rq = 1; step();
        next_rq = 0; step();
        gnt_wd = 1; step();
        gnt_wd = 0; w_ready = 1; next_rq = 1; b_valid = 1; b_id = 4'h3; #1;
        vectors++;
        if ({ren_id_data, b_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL simul_both: got %b want 11", {ren_id_data, b_ready});
        end
        step();
        w_ready = 0; next_rq = 0; b_valid = 0; #1;
        vectors++;
        if (dut.pend_cnt_q !== 3'd1 || dut.outs_cnt_q !== 3'd1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_cnts: got pend %0d outs %0d err %b want 1 1 0",
                     dut.pend_cnt_q, dut.outs_cnt_q, err);
        end
        vectors++;
        if (wr_done !== 1'b1 || wr_done_id !== 4'h3) begin
            miscompares++;
            $display("FAIL simul_done: got %b id %h want 1 3", wr_done, wr_done_id);
        end
        gnt_wd = 1; w_ready = 1;
        for (int c = 0; c < 6; c++) step();
        gnt_wd = 0; w_ready = 0;
        b_valid = 1; step(); step();
        b_valid = 0; #1;
        vectors++;
        if (dut.outs_cnt_q !== 3'd0 || dut.pend_cnt_q !== 3'd0) begin
            miscompares++;
            $display("FAIL simul_drain: got outs %0d pend %0d want 0 0",
                     dut.outs_cnt_q, dut.pend_cnt_q);
        end
    endtask

    task automatic test_foreign_id();
        b_valid = 1; b_id = 4'h9; #1;
        vectors++;
        if (b_ready !== 1'b0) begin
            miscompares++; $display("FAIL foreign_bready: got %b want 0", b_ready);
        end
        step();
        b_valid = 0; #1;
        vectors++;
        if (wr_done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL foreign_quiet: got done %b err %b want 0 0", wr_done, err);
        end
        b_valid = 1; b_id = 4'h2; #1;
        vectors++;
        if (b_ready !== 1'b0) begin
            miscompares++; $display("FAIL orphan_bready: got %b want 0", b_ready);
        end
        step();
        b_valid = 0; #1;
        vectors++;
        if (err !== 1'b1 || wr_done !== 1'b0 || dut.outs_cnt_q !== 3'd0) begin
            miscompares++;
            $display("FAIL orphan_err: got err %b done %b outs %0d want 1 0 0",
                     err, wr_done, dut.outs_cnt_q);
        end
    endtask

    task automatic test_reset_mid();
        next_id = 4'h1;
        next_rq = 1; step();
        next_rq = 0; step();
        gnt_wd = 1; step();
        gnt_wd = 0; #1;
        vectors++;
        if (w_valid !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_out: got %b want 1", w_valid);
        end
        w_ready = 1; rst_n = 1'b0; #1;
        vectors++;
        if ({w_valid, req_wd, ren_id_data, wr_done, err} !== 5'b0) begin
            miscompares++;
            $display("FAIL rstmid_outs: got %b want 00000",
                     {w_valid, req_wd, ren_id_data, wr_done, err});
        end
        vectors++;
        if (dut.pend_cnt_q !== 3'd0 || dut.outs_cnt_q !== 3'd0) begin
            miscompares++;
            $display("FAIL rstmid_cnts: got pend %0d outs %0d want 0 0",
                     dut.pend_cnt_q, dut.outs_cnt_q);
        end
        w_ready = 0; step(); step();
        rst_n = 1'b1;
        next_rq = 1; step();
        next_rq = 0; step();
        gnt_wd = 1; step();
        gnt_wd = 0; w_ready = 1; #1;
        vectors++;
        if (ren_id_data !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_clean_ren: got %b want 1", ren_id_data);
        end
        step();
        w_ready = 0; b_valid = 1; b_id = 4'h1; step();
        b_valid = 0; #1;
        vectors++;
        if (wr_done !== 1'b1 || wr_done_id !== 4'h1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_clean_done: got done %b id %h err %b want 1 1 0",
                     wr_done, wr_done_id, err);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_four_writes();
        test_simultaneous();
        test_foreign_id();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
